pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) replacing hand-written per-stage latches.
//  - Carries a DATA_W payload plus a CTRL_W control bundle with a valid/ready handshake.
//  - Adds stall (back-pressure), flush and bubble insertion.
//  - The control bundle collapses to a NOP pattern whenever the stage holds no valid entry.
// PARAMETERS
//  DATA_W    32             payload width (pc, operands, imm, inst, reg indices, concatenated)
//  CTRL_W    16             control bundle width (reg write, mem rd/wr, alu op, ...)
//  CTRL_NOP  {CTRL_W{1'b0}} control value presented on bubble/reset; set active-low enables to 1 here
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst_n        in   1       reset, synchronous, active-low
//  valid_i      in   1       upstream entry valid
//  ready_o      out  1       stage can accept; transfer in = valid_i & ready_o
//  data_i       in   DATA_W  upstream payload
//  ctrl_i       in   CTRL_W  upstream control bundle
//  flush_i      in   1       kill all held entries (branch/jump redirect)
//  valid_o      out  1       downstream entry valid
//  ready_i      in   1       downstream can accept; transfer out = valid_o & ready_i
//  data_o       out  DATA_W  held payload
//  ctrl_o       out  CTRL_W  held control; CTRL_NOP when valid_o=0
//  occ_o        out  2       entries held (0..2; max 1 without skid)
// BEHAVIOUR
//  - Reset: rst_n sampled low at posedge clears every entry.
//    -> valid_o=0, data_o=0, ctrl_o=CTRL_NOP, occ_o=0, ready_o=1 from the following cycle.
//    Overrides flush and any in-flight handshake.
//  - Storage: main entry (drives outputs) plus optional skid entry; FIFO order always preserved.
//  - Latency: one cycle data_i -> data_o when the stage is empty or draining.
//  - Bubble: ctrl_o = CTRL_NOP combinationally whenever valid_o=0; data_o holds its last value (don't care).
//  - Empty stage, in-fire: main loads; valid_o=1 next cycle.
//  - Main full, out-fire & in-fire same cycle: main reloads with new entry; occ unchanged.
//  - Main full, out-fire only: main empties (or takes skid entry if present).
//  - Main full, no out-fire, in-fire: entry goes to skid (skid build only).
//  - Stall (valid_o=1, ready_i=0): data_o/ctrl_o/valid_o held stable, bit-exact.
//  - Flush: flush_i=1 at posedge drops main and skid.
//    -> next cycle valid_o=0, ctrl_o=CTRL_NOP, occ_o=0.
//    An in-fire in the flush cycle is discarded. Flush wins over stall and over simultaneous in/out fire.
//    The downstream out-fire in that cycle still counts as delivered.
//  - occ_o: +1 on accepted in-fire, -1 on out-fire, net 0 on both; forced 0 on flush/reset; never exceeds capacity.
//  - No combinational path from valid_i/data_i/ctrl_i to any output.
// CONFIGURATION
//  PIPE_REG_SKID_EN defined:
//  - 2-entry skid buffer; ready_o is a register output, = (occ_o != 2).
//  - Full throughput with no comb ready_i -> ready_o path.
//  PIPE_REG_SKID_EN undefined:
//  - Single entry; ready_o = ~valid_o | ready_i (combinational).
//  - occ_o[1] tied 0; all other rules unchanged.
// TESTING
//  (DATA_W=32, CTRL_W=8, CTRL_NOP=8'h01, both macro settings unless noted)
//  1. Reset: rst_n=0 one cycle with valid_i=1, data_i=32'hDEADBEEF, flush_i=1
//     -> valid_o=0, data_o=0, ctrl_o=8'h01, occ_o=0; ready_o=1 next cycle.
//  2. Streaming: valid_i=1 every cycle, ready_i=1, data_i=0,1,2,...
//     -> data_o=0,1,2,... one cycle later, no gaps, occ_o=1 steady.
//  3. Stall: hold entry 32'h100, ctrl 8'h5A, ready_i=0 for 4 cycles
//     -> data_o/ctrl_o unchanged all 4 cycles; release -> 32'h100 out exactly once.
//  4. Skid (SKID_EN): ready_i drops while entries A,B,C offered
//     -> A in main, B in skid, occ_o=2, ready_o=0, C held upstream; ready_i=1 -> A,B,C in order.
//  5. Flush: occ_o=2, flush_i=1 with in-fire of 32'h77
//     -> next cycle valid_o=0, ctrl_o=8'h01, occ_o=0; 32'h77 never appears on data_o.
//  6. Random valid_i/ready_i/flush_i (10k cycles) vs scoreboard
//     -> no loss, dup or reorder except flushed entries; ctrl_o=CTRL_NOP whenever valid_o=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready
// handshake, flush and bubble insertion.
// Optional feature macro: PIPE_REG_SKID_EN.
// - Defined: adds a second (skid) entry and registers ready_o, so there is
//   no combinational path from ready_i to ready_o.
// - Undefined: single entry, and ready_o = ~valid_o | ready_i.
// The control bundle reads as CTRL_NOP whenever the stage holds no valid entry.
module pipe_stage_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        occ_o
);

  // Main entry: always the oldest entry, and the one that drives the outputs.
  logic              main_vld_q,  main_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = main_vld_q & ready_i;

  // Outputs come straight from registers; only ctrl is masked to a NOP when
  // the stage is empty, so a bubble can never assert downstream enables.
  assign valid_o = main_vld_q;
  assign data_o  = main_data_q;
  assign ctrl_o  = main_vld_q ? main_ctrl_q : CTRL_NOP;

`ifdef PIPE_REG_SKID_EN

  // The skid entry holds the one beat accepted while main was stalled.
  // The skid entry is only ever valid while main is also valid.
  logic              skid_vld_q,  skid_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              ready_q,     ready_d;

  assign ready_o = ready_q;
  // Occupancy encoding: 2 when skid is valid, 1 when only main is valid, else 0.
  assign occ_o   = {skid_vld_q, main_vld_q & ~skid_vld_q};

  // Next-state logic for the two entries. Flush takes priority over every
  // handshake. FIFO order is kept: skid always refills main first.
  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      if (in_fire) begin
        main_vld_d  = 1'b1;
        main_data_d = data_i;
        main_ctrl_d = ctrl_i;
      end
    end else if (out_fire) begin
      if (skid_vld_q) begin
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
        // ready_o is low while the skid entry is full, so this refill of
        // skid never fires in practice; it is kept so that order is still
        // preserved if it ever did.
        if (in_fire) begin
          skid_data_d = data_i;
          skid_ctrl_d = ctrl_i;
        end else begin
          skid_vld_d = 1'b0;
        end
      end else if (in_fire) begin
        main_data_d = data_i;
        main_ctrl_d = ctrl_i;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d  = 1'b1;
      skid_data_d = data_i;
      skid_ctrl_d = ctrl_i;
    end
    // ready_o is computed one cycle ahead from the next occupancy, so it
    // reads as (occ_o != 2) with no path from ready_i.
    ready_d = ~(main_vld_d & skid_vld_d);
  end

  // State registers for both entries and the registered ready.
  // Synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
      ready_q     <= 1'b1;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      ready_q     <= ready_d;
    end
  end

`else

  // Single entry: the stage accepts when it is empty or is draining this cycle.
  assign ready_o = ~main_vld_q | ready_i;
  assign occ_o   = {1'b0, main_vld_q};

  // Next-state logic for the main entry. Flush wins. With a single entry,
  // an in-fire while main is full implies an out-fire in the same cycle,
  // so main simply reloads.
  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
    end else if (in_fire) begin
      main_vld_d  = 1'b1;
      main_data_d = data_i;
      main_ctrl_d = ctrl_i;
    end else if (out_fire) begin
      main_vld_d = 1'b0;
    end
  end

  // Main entry register. Synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against
// a queue-based reference model. The model capacity follows PIPE_REG_SKID_EN.
module tb_pipe_stage_reg;

  localparam int         DW  = 32;
  localparam int         CW  = 8;
  localparam logic [7:0] NOP = 8'h01;

  logic          clk = 1'b0;
  logic          rst_n, valid_i, ready_i, flush_i;
  logic          ready_o, valid_o;
  logic [DW-1:0] data_i, data_o;
  logic [CW-1:0] ctrl_i, ctrl_o;
  logic [1:0]    occ_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .ctrl_i(ctrl_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o), .occ_o(occ_o)
  );

  // Reference model: an in-order queue of the entries the stage holds.
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];
  bit   watch77;
  bit   seen77;
  int   cnt100;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The stage accepts when it is not full. Without skid it also accepts when
  // it drains this cycle.
  function automatic bit m_ready(input bit r);
`ifdef PIPE_REG_SKID_EN
    return q.size() != 2;
`else
    return q.size() == 0 || r;
`endif
  endfunction

  // One clock: drive the inputs after negedge, compare the outputs, then
  // advance the model at posedge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit r, input bit f);
    bit in_f, out_f;
    @(negedge clk);
    rst_n = 1'b1; valid_i = v; data_i = d; ctrl_i = c; ready_i = r; flush_i = f;
    #1;
    chk("ready_o", 64'(ready_o), 64'(m_ready(r)));
    chk("valid_o", 64'(valid_o), 64'(q.size() != 0));
    chk("occ_o",   64'(occ_o),   64'(q.size()));
    chk("ctrl_o",  64'(ctrl_o),  64'((q.size() != 0) ? q[0].c : NOP));
    if (q.size() != 0) chk("data_o", 64'(data_o), 64'(q[0].d));
    in_f  = v & m_ready(r);
    out_f = (q.size() != 0) & r;
    if (out_f && watch77 && data_o == 32'h77) seen77 = 1'b1;
    if (out_f && data_o == 32'h100) cnt100++;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back('{d: d, c: c});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid_i = 1'b1; data_i = 32'hDEADBEEF; ctrl_i = 8'hA5;
    flush_i = 1'b1; ready_i = 1'b1;
    @(posedge clk);
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    data_i = '0; ctrl_i = '0; watch77 = 1'b0; seen77 = 1'b0; cnt100 = 0;

    // Reset with a live handshake and a flush on the inputs.
    do_reset();
    @(negedge clk);
    #1;
    chk("rst_data", 64'(data_o), 64'h0);
    chk("rst_ctrl", 64'(ctrl_o), 64'(NOP));
    chk("rst_occ",  64'(occ_o),  64'h0);
    chk("rst_rdy",  64'(ready_o), 64'h1);

    // Streaming: back-to-back beats with no gaps.
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i), 8'(i + 3), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall: hold one entry for 4 cycles, then release it exactly once.
    cnt100 = 0;
    cycle(1'b1, 32'h100, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stall_once", 64'(cnt100), 64'h1);

    // Offer A, B, C while downstream stalls. The model fixes the capacity
    // (skid: A and B held, occ=2, ready low); all then drain in order.
    cycle(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0);
`ifdef PIPE_REG_SKID_EN
    chk("skid_occ", 64'(q.size()), 64'h2);
`endif
    cycle(1'b1, 32'hC, 8'h0C, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush from a full stage while an in-fire of 0x77 is offered.
    cycle(1'b1, 32'h55, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h66, 8'h22, 1'b0, 1'b0);
    watch77 = 1'b1; seen77 = 1'b0;
    cycle(1'b1, 32'h77, 8'h33, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_77", 64'(seen77), 64'h0);
    watch77 = 1'b0;

    // Random traffic, with occasional flushes and resets.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(1'($urandom_range(0, 3) != 0), 32'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
